ysyx_22040895_ifu: RTL and testbench

- Instruction fetch stage, directly upstream of the control unit.
- Holds the PC and issues fetches to instruction memory over a valid/ready request and a valid-only response.
- Buffers one instruction and presents it, with its PC and pre-split opcode/func3/func7 fields, to decode over a valid/ready handshake.
- Accepts a redirect (jump_branch/target) and discards any fetch made stale by it.

---
 rtl/ysyx_22040895_ifu.sv | 133 +++++++++++++
 tb/tb_ysyx_22040895_ifu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch stage: holds the PC, fetches one word at a time and hands it to decode.
// Optional target alignment trap is enabled by defining YSYX_22040895_IFU_MISALIGN_CHECK_EN.
module ysyx_22040895_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_branch_i_ifu,
  input  logic [XLEN-1:0] target_i_ifu,
  output logic            imem_req_valid_o_ifu,
  input  logic            imem_req_ready_i_ifu,
  output logic [XLEN-1:0] imem_addr_o_ifu,
  input  logic            imem_resp_valid_i_ifu,
  input  logic [31:0]     imem_rdata_i_ifu,
  output logic            inst_valid_o_ifu,
  input  logic            inst_ready_i_ifu,
  output logic [31:0]     inst_o_ifu,
  output logic [XLEN-1:0] pc_o_ifu,
  output logic [6:0]      opcode_o_ifu,
  output logic [2:0]      func3_o_ifu,
  output logic [6:0]      func7_o_ifu
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
  ,
  output logic            misalign_o_ifu
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic [31:0]     inst_q;
  logic            inst_valid_q;
  logic            parked;

`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
  logic misalign_q;
  logic bad_target;

  assign bad_target     = |target_i_ifu[1:0];
  assign parked         = misalign_q;
  assign misalign_o_ifu = misalign_q;
`else
  assign parked = 1'b0;
`endif

  // A redirect in the same cycle masks the request so the stale PC never reaches memory.
  assign imem_req_valid_o_ifu = rst & (state_q == S_REQ) & ~jump_branch_i_ifu & ~parked;
  assign imem_addr_o_ifu      = pc_q;
  assign pc_o_ifu             = pc_q;
  assign inst_valid_o_ifu     = inst_valid_q;
  assign inst_o_ifu           = inst_q;
  assign opcode_o_ifu         = inst_q[6:0];
  assign func3_o_ifu          = inst_q[14:12];
  assign func7_o_ifu          = inst_q[31:25];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else if (!parked) begin
      unique case (state_q)
        S_REQ: begin
          if (jump_branch_i_ifu) begin
            pc_q <= target_i_ifu;
          end else if (imem_req_ready_i_ifu) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (jump_branch_i_ifu) begin
            pc_q <= target_i_ifu;
            // A response arriving with the redirect is the stale one; nothing left to drop.
            if (imem_resp_valid_i_ifu) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_resp_valid_i_ifu) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q       <= imem_rdata_i_ifu;
              inst_valid_q <= 1'b1;
              state_q      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (jump_branch_i_ifu) begin
            pc_q         <= target_i_ifu;
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end else if (inst_ready_i_ifu) begin
            pc_q         <= pc_q + XLEN'(4);
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
      // Misaligned redirect: load the PC, kill everything in flight and park until reset.
      if (jump_branch_i_ifu && bad_target) begin
        pc_q         <= target_i_ifu;
        drop_q       <= 1'b0;
        inst_valid_q <= 1'b0;
        state_q      <= S_REQ;
        misalign_q   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Directed bench for ysyx_22040895_ifu: a per-cycle vector table plus hand sequences
// for wrap-around, reset mid-fetch and the optional misalignment trap.
module tb_ysyx_22040895_ifu;

  localparam logic [63:0] A   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] T1  = 64'h0000_0000_8000_0100;
  localparam logic [63:0] T2  = 64'h0000_0000_8000_0200;
  localparam logic [63:0] T3  = 64'h0000_0000_8000_0300;
  localparam logic [63:0] T4  = 64'h0000_0000_8000_0400;
  localparam logic [63:0] T5  = 64'h0000_0000_8000_0500;
  localparam logic [63:0] TW  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] TM  = 64'h0000_0000_8000_0102;
  localparam logic [31:0] D0  = 32'h0050_0093;
  localparam logic [31:0] D1  = 32'h00a0_0113;
  localparam logic [31:0] D2  = 32'h0020_81b3;
  localparam logic [31:0] D3  = 32'h4020_8233;
  localparam logic [31:0] D4  = 32'h0000_6293;
  localparam logic [31:0] STL = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        rst;
  logic        jb;
  logic [63:0] tgt;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_22040895_ifu dut (
    .clk                  (clk),
    .rst                  (rst),
    .jump_branch_i_ifu    (jb),
    .target_i_ifu         (tgt),
    .imem_req_valid_o_ifu (req_valid),
    .imem_req_ready_i_ifu (req_ready),
    .imem_addr_o_ifu      (addr),
    .imem_resp_valid_i_ifu(resp_valid),
    .imem_rdata_i_ifu     (rdata),
    .inst_valid_o_ifu     (inst_valid),
    .inst_ready_i_ifu     (inst_ready),
    .inst_o_ifu           (inst),
    .pc_o_ifu             (pc),
    .opcode_o_ifu         (opcode),
    .func3_o_ifu          (func3),
    .func7_o_ifu          (func7)
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
    ,
    .misalign_o_ifu       (misalign)
`endif
  );

  typedef struct {
    logic        jb;
    logic [63:0] tgt;
    logic        rdy;
    logic        rsp;
    logic [31:0] rd;
    logic        irdy;
    logic        e_rqv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic j, logic [63:0] t, logic r, logic s, logic [31:0] d,
                              logic ir, logic erq, logic [63:0] ea, logic eiv, logic [31:0] ei);
    vec_t v;
    v.jb = j; v.tgt = t; v.rdy = r; v.rsp = s; v.rd = d; v.irdy = ir;
    v.e_rqv = erq; v.e_addr = ea; v.e_iv = eiv; v.e_inst = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic j, input logic [63:0] t, input logic r, input logic s,
                       input logic [31:0] d, input logic ir);
    jb = j; tgt = t; req_ready = r; resp_valid = s; rdata = d; inst_ready = ir;
    #1;
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] ei, input logic [63:0] ep);
    logic [31:0] e;
    e = ei;
    chk({tag, "_inst"}, 64'(inst), 64'(e));
    chk({tag, "_pc"}, pc, ep);
    chk({tag, "_opcode"}, 64'(opcode), 64'(e[6:0]));
    chk({tag, "_func3"}, 64'(func3), 64'(e[14:12]));
    chk({tag, "_func7"}, 64'(func7), 64'(e[31:25]));
  endtask

  initial begin
    // Row: jb tgt rdy rsp rdata irdy | req_valid addr inst_valid inst
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, A,      0, 0));   // first fetch
    vq.push_back(mk(0, 0, 0, 1, D0,  0, 0, A,      0, 0));
    for (int k = 0; k < 5; k++)                              // decode stalls, memory idle-ready
      vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, A,      1, D0));
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A,      1, D0));
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, A + 4,  0, 0));   // back-to-back, 3 cycles each
    vq.push_back(mk(0, 0, 0, 1, D1,  0, 0, A + 4,  0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A + 4,  1, D1));
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, A + 8,  0, 0));
    vq.push_back(mk(0, 0, 0, 1, D2,  0, 0, A + 8,  0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, A + 8,  1, D2));
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, A + 12, 0, 0));
    vq.push_back(mk(1, T1, 0, 0, 0,  0, 0, A + 12, 0, 0));   // redirect in S_WAIT
    vq.push_back(mk(0, 0, 0, 0, 0,   0, 0, T1,     0, 0));
    vq.push_back(mk(0, 0, 0, 1, STL, 0, 0, T1,     0, 0));   // stale response dropped
    vq.push_back(mk(0, 0, 0, 0, 0,   0, 1, T1,     0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, T1,     0, 0));
    vq.push_back(mk(0, 0, 0, 1, D3,  0, 0, T1,     0, 0));
    vq.push_back(mk(1, T2, 0, 0, 0,  1, 0, T1,     1, D3));  // redirect + accept in S_OUT
    vq.push_back(mk(0, 0, 0, 0, 0,   0, 1, T2,     0, 0));
    vq.push_back(mk(1, T3, 1, 0, 0,  0, 0, T2,     0, 0));   // redirect masks request
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, T3,     0, 0));
    vq.push_back(mk(1, T4, 0, 1, STL, 0, 0, T3,    0, 0));   // redirect with same-cycle response
    vq.push_back(mk(0, 0, 0, 0, 0,   0, 1, T4,     0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0,   0, 1, T4,     0, 0));
    vq.push_back(mk(0, 0, 0, 1, D4,  0, 0, T4,     0, 0));
    vq.push_back(mk(1, T5, 0, 0, 0,  0, 0, T4,     1, D4));  // redirect flushes unaccepted inst
    vq.push_back(mk(0, 0, 0, 0, 0,   0, 1, T5,     0, 0));

    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'h13);
    chk("rst_pc", pc, A);
    chk("rst_addr", addr, A);
`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
    chk("rst_misalign", 64'(misalign), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].jb, vq[i].tgt, vq[i].rdy, vq[i].rsp, vq[i].rd, vq[i].irdy);
      chk($sformatf("v%0d_req_valid", i), 64'(req_valid), 64'(vq[i].e_rqv));
      chk($sformatf("v%0d_addr", i), addr, vq[i].e_addr);
      chk($sformatf("v%0d_inst_valid", i), 64'(inst_valid), 64'(vq[i].e_iv));
      if (vq[i].e_iv) chk_inst($sformatf("v%0d", i), vq[i].e_inst, vq[i].e_addr);
      $display("vec %0d: req_valid=%0b addr=%h inst_valid=%0b inst=%h", i, req_valid, addr, inst_valid, inst);
      @(negedge clk);
    end

    // PC increment wraps past the top of the address space.
    drive(1, TW, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    chk("wrap_req_valid", 64'(req_valid), 64'd1);
    chk("wrap_addr", addr, TW);
    @(negedge clk);
    drive(0, 0, 0, 1, D1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    chk("wrap_inst_valid", 64'(inst_valid), 64'd1);
    chk_inst("wrap", D1, TW);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_next_addr", addr, 64'd0);
    chk("wrap_next_req", 64'(req_valid), 64'd1);
    $display("wrap: next addr=%h", addr);

    // Reset while a fetch is outstanding; the late response must be ignored.
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    chk("mid_req_accept", 64'(req_valid), 64'd1);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_req_valid", 64'(req_valid), 64'd0);
    chk("mid_rst_addr", addr, A);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 1, STL, 0);
    chk("mid_after_req_valid", 64'(req_valid), 64'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_after_inst_valid", 64'(inst_valid), 64'd0);
    chk("mid_after_addr", addr, A);
    $display("reset mid-fetch: inst_valid=%0b addr=%h", inst_valid, addr);

`ifdef YSYX_22040895_IFU_MISALIGN_CHECK_EN
    drive(1, TM, 1, 0, 0, 0);
    chk("mis_req_masked", 64'(req_valid), 64'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, STL, 1);
      chk($sformatf("mis%0d_flag", k), 64'(misalign), 64'd1);
      chk($sformatf("mis%0d_req_valid", k), 64'(req_valid), 64'd0);
      chk($sformatf("mis%0d_inst_valid", k), 64'(inst_valid), 64'd0);
      chk($sformatf("mis%0d_addr", k), addr, TM);
      $display("misalign cycle %0d: misalign=%0b req_valid=%0b", k, misalign, req_valid);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("mis_rst_flag", 64'(misalign), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("mis_rst_req_valid", 64'(req_valid), 64'd1);
`else
    drive(1, TM, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("unaligned_addr", addr, TM);
    chk("unaligned_req_valid", 64'(req_valid), 64'd1);
    $display("unaligned redirect: addr=%h req_valid=%0b", addr, req_valid);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
